// File: rtl/snn_pkg.sv
// Shared constants for the SNN weight store: network geometry, SRAM
// address/data widths and bank-select encodings.
package snn_pkg;

  localparam int NUM_PIXELS        = 196;
  localparam int OUTPUTS           = 10;
  localparam int HALF_PIXELS       = NUM_PIXELS >> 1;
  localparam int ADDR_W            = 10;
  localparam int DATA_W            = 8;
  localparam int PIX_W             = 8;
  localparam int OUT_W             = 4;
  localparam int HOST_MAX_WAIT_DEF = 4;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/snn_weight_addr_map.sv
// Maps an engine (pixel, output) pair onto a weight bank and a bank-local
// address. Pixels below HALF_PIXELS live in bank 0, the rest in bank 1,
// each stored as OUTPUTS consecutive weights per pixel.
module snn_weight_addr_map
  import snn_pkg::*;
(
  input  logic [PIX_W-1:0]  pixel,
  input  logic [OUT_W-1:0]  out_idx,
  output logic              bank,
  output logic [ADDR_W-1:0] loc_addr,
  output logic              err
);

  localparam logic [PIX_W-1:0]  HALF_C = PIX_W'(HALF_PIXELS);
  localparam logic [PIX_W-1:0]  NPIX_C = PIX_W'(NUM_PIXELS);
  localparam logic [OUT_W-1:0]  NOUT_C = OUT_W'(OUTPUTS);
  localparam logic [ADDR_W-1:0] MUL_C  = ADDR_W'(OUTPUTS);

  logic [PIX_W-1:0] rel_pixel;

  // Bank select, bank-relative pixel and 10-bit local address.
  always_comb begin
    bank      = (pixel >= HALF_C) ? BANK1 : BANK0;
    rel_pixel = (bank == BANK1) ? (pixel - HALF_C) : pixel;
    loc_addr  = ADDR_W'(rel_pixel) * MUL_C + ADDR_W'(out_idx);
    err       = (pixel >= NPIX_C) || (out_idx >= NOUT_C);
  end

endmodule

// File: rtl/snn_weight_arbiter.sv
// Arbitrates the two single-port weight SRAM banks between the host write
// path and the engine read path. Engine wins same-bank conflicts unless the
// host has been starved long enough to earn a one-shot boost. Read data
// returns exactly one cycle after the engine request is accepted.
module snn_weight_arbiter
  import snn_pkg::*;
#(
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic              host_wr_bank,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              eng_req_valid,
  output logic              eng_req_ready,
  input  logic [PIX_W-1:0]  eng_req_pixel,
  input  logic [OUT_W-1:0]  eng_req_output,
  output logic              eng_rsp_valid,
  output logic [DATA_W-1:0] eng_rsp_data,
  output logic              eng_rsp_err,
  output logic [1:0]        bank_csb,
  output logic [1:0]        bank_web,
  output logic [ADDR_W-1:0] bank_addr0,
  output logic [ADDR_W-1:0] bank_addr1,
  output logic [DATA_W-1:0] bank_din,
  input  logic [DATA_W-1:0] bank0_dout,
  input  logic [DATA_W-1:0] bank1_dout
);

  localparam int                WAIT_W   = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  logic              map_bank;
  logic [ADDR_W-1:0] map_addr;
  logic              map_err;
  logic              conflict;
  logic              host_gnt;
  logic              eng_gnt;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic              boost_q, boost_d;
  logic              rsp_pending_q, rsp_pending_d;
  logic              rsp_bank_q, rsp_bank_d;
  logic              rsp_err_q, rsp_err_d;

  snn_weight_addr_map u_addr_map (
    .pixel    (eng_req_pixel),
    .out_idx  (eng_req_output),
    .bank     (map_bank),
    .loc_addr (map_addr),
    .err      (map_err)
  );

  // Grant decision: out-of-range engine requests never touch a bank, so
  // they cannot conflict with the host.
  always_comb begin
    conflict = 1'b0;
    host_gnt = 1'b0;
    eng_gnt  = 1'b0;
    if (!wb_rst_i) begin
      conflict = host_wr_valid && eng_req_valid && !map_err &&
                 (host_wr_bank == map_bank);
      host_gnt = host_wr_valid && (!conflict || boost_q);
      eng_gnt  = eng_req_valid && (!conflict || !boost_q);
    end
  end

  assign host_wr_ready = host_gnt;
  assign eng_req_ready = eng_gnt;

  // SRAM control lines driven straight from the grants; macros sample them
  // on the next clock edge.
  always_comb begin
    bank_csb   = 2'b11;
    bank_web   = 2'b11;
    bank_addr0 = '0;
    bank_addr1 = '0;
    bank_din   = '0;
    if (host_gnt) begin
      bank_csb[host_wr_bank] = 1'b0;
      bank_web[host_wr_bank] = 1'b0;
      bank_din               = host_wr_data;
      if (host_wr_bank == BANK1) bank_addr1 = host_wr_addr;
      else                       bank_addr0 = host_wr_addr;
    end
    if (eng_gnt && !map_err) begin
      bank_csb[map_bank] = 1'b0;
      if (map_bank == BANK1) bank_addr1 = map_addr;
      else                   bank_addr0 = map_addr;
    end
  end

  // Host starvation counter: counts lost conflicts, holds while the host is
  // idle, and arms the boost once the limit is reached.
  always_comb begin
    wait_inc   = wait_cnt_q + WAIT_W'(1);
    wait_cnt_d = wait_cnt_q;
    boost_d    = boost_q;
    if (host_gnt) begin
      wait_cnt_d = '0;
      boost_d    = 1'b0;
    end else if (conflict && !boost_q) begin
      if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_inc;
      if (wait_inc == WAIT_MAX)   boost_d    = 1'b1;
    end
  end

  // Response tracking for the request accepted this cycle.
  always_comb begin
    rsp_pending_d = eng_gnt;
    rsp_bank_d    = map_bank;
    rsp_err_d     = map_err;
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wait_cnt_q    <= '0;
      boost_q       <= 1'b0;
      rsp_pending_q <= 1'b0;
      rsp_bank_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      boost_q       <= boost_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_bank_q    <= rsp_bank_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign eng_rsp_valid = rsp_pending_q;
  assign eng_rsp_err   = rsp_pending_q && rsp_err_q;
  assign eng_rsp_data  = (rsp_pending_q && !rsp_err_q) ?
                         ((rsp_bank_q == BANK1) ? bank1_dout : bank0_dout) : '0;

endmodule

// File: tb/tb_snn_weight_arbiter.sv
// Bench for snn_weight_arbiter: two behavioural single-port SRAMs with a
// one-cycle read, scenario tasks, and a response scoreboard.
module tb_snn_weight_arbiter;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_wr_valid, host_wr_ready, host_wr_bank;
  logic [9:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       eng_req_valid, eng_req_ready;
  logic [7:0] eng_req_pixel;
  logic [3:0] eng_req_output;
  logic       eng_rsp_valid, eng_rsp_err;
  logic [7:0] eng_rsp_data;
  logic [1:0] bank_csb, bank_web;
  logic [9:0] bank_addr0, bank_addr1;
  logic [7:0] bank_din, bank0_dout, bank1_dout;

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  exp_t       exp_q [$];
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  snn_weight_arbiter dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_bank   (host_wr_bank),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .eng_req_valid  (eng_req_valid),
    .eng_req_ready  (eng_req_ready),
    .eng_req_pixel  (eng_req_pixel),
    .eng_req_output (eng_req_output),
    .eng_rsp_valid  (eng_rsp_valid),
    .eng_rsp_data   (eng_rsp_data),
    .eng_rsp_err    (eng_rsp_err),
    .bank_csb       (bank_csb),
    .bank_web       (bank_web),
    .bank_addr0     (bank_addr0),
    .bank_addr1     (bank_addr1),
    .bank_din       (bank_din),
    .bank0_dout     (bank0_dout),
    .bank1_dout     (bank1_dout)
  );

  function automatic logic [7:0] init0(input int a);
    return (a == 37) ? 8'h5A : 8'(a * 7 + 3);
  endfunction

  function automatic logic [7:0] init1(input int a);
    return (a == 22) ? 8'hC3 : 8'(a * 5 + 1);
  endfunction

  // Behavioural SRAM macros, reloaded with known contents during reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= init0(i);
        mem1[i] <= init1(i);
      end
      bank0_dout <= 8'h00;
      bank1_dout <= 8'h00;
    end else begin
      if (!bank_csb[0]) begin
        if (!bank_web[0]) mem0[bank_addr0] <= bank_din;
        else              bank0_dout <= mem0[bank_addr0];
      end
      if (!bank_csb[1]) begin
        if (!bank_web[1]) mem1[bank_addr1] <= bank_din;
        else              bank1_dout <= mem1[bank_addr1];
      end
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (eng_rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected got err=%b data=%h want no response",
                 eng_rsp_err, eng_rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({eng_rsp_err, eng_rsp_data} !== {e.err, e.data})
          $display("FAIL rsp_data got err=%b data=%h want err=%b data=%h",
                   eng_rsp_err, eng_rsp_data, e.err, e.data);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_wr_valid  = 1'b0;
    host_wr_bank   = 1'b0;
    host_wr_addr   = '0;
    host_wr_data   = '0;
    eng_req_valid  = 1'b0;
    eng_req_pixel  = '0;
    eng_req_output = '0;
  endtask

  task automatic eng_req(input logic [7:0] px, input logic [3:0] o);
    eng_req_valid  = 1'b1;
    eng_req_pixel  = px;
    eng_req_output = o;
  endtask

  task automatic host_req(input logic b, input logic [9:0] a, input logic [7:0] d);
    host_wr_valid = 1'b1;
    host_wr_bank  = b;
    host_wr_addr  = a;
    host_wr_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    host_req(1'b0, 10'd3, 8'hAA);
    eng_req(8'd3, 4'd7);
    @(negedge clk);
    checks++;
    if ({host_wr_ready, eng_req_ready} !== 2'b00)
      $display("FAIL reset_ready got %b want 00", {host_wr_ready, eng_req_ready});
    else passed++;
    checks++;
    if ({bank_csb, bank_web} !== 4'b1111)
      $display("FAIL reset_ctrl got csb=%b web=%b want 11/11", bank_csb, bank_web);
    else passed++;
    checks++;
    if ({bank_addr0, bank_addr1, bank_din} !== 28'd0)
      $display("FAIL reset_bus got a0=%0d a1=%0d din=%h want 0", bank_addr0, bank_addr1, bank_din);
    else passed++;
    checks++;
    if ({eng_rsp_valid, eng_rsp_err, eng_rsp_data} !== 10'd0)
      $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", eng_rsp_valid, eng_rsp_err, eng_rsp_data);
    else passed++;
    tick();
    idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_bank0();
    eng_req(8'd3, 4'd7);
    @(negedge clk);
    checks++;
    if ({eng_req_ready, bank_addr0, bank_csb, bank_web} !== {1'b1, 10'd37, 2'b10, 2'b11})
      $display("FAIL rd0_ctrl got rdy=%b a0=%0d csb=%b web=%b want 1/37/10/11",
               eng_req_ready, bank_addr0, bank_csb, bank_web);
    else passed++;
    exp_q.push_back('{err: 1'b0, data: 8'h5A});
    tick();
    idle();
    tick();
  endtask

  task automatic test_read_bank1();
    eng_req(8'd100, 4'd2);
    @(negedge clk);
    checks++;
    if ({eng_req_ready, bank_addr1, bank_csb, bank_web} !== {1'b1, 10'd22, 2'b01, 2'b11})
      $display("FAIL rd1_ctrl got rdy=%b a1=%0d csb=%b web=%b want 1/22/01/11",
               eng_req_ready, bank_addr1, bank_csb, bank_web);
    else passed++;
    exp_q.push_back('{err: 1'b0, data: 8'hC3});
    tick();
    idle();
    tick();
  endtask

  task automatic test_parallel();
    host_req(1'b0, 10'd5, 8'h11);
    eng_req(8'd150, 4'd0);
    @(negedge clk);
    checks++;
    if ({host_wr_ready, eng_req_ready, bank_csb, bank_web} !== 6'b11_00_10)
      $display("FAIL par_ctrl got hr=%b er=%b csb=%b web=%b want 1/1/00/10",
               host_wr_ready, eng_req_ready, bank_csb, bank_web);
    else passed++;
    checks++;
    if ({bank_addr0, bank_addr1, bank_din} !== {10'd5, 10'd520, 8'h11})
      $display("FAIL par_bus got a0=%0d a1=%0d din=%h want 5/520/11",
               bank_addr0, bank_addr1, bank_din);
    else passed++;
    exp_q.push_back('{err: 1'b0, data: init1(520)});
    tick();
    idle();
    eng_req(8'd0, 4'd5);
    @(negedge clk);
    exp_q.push_back('{err: 1'b0, data: 8'h11});
    tick();
    idle();
    tick();
  endtask

  task automatic test_boost();
    logic want_host;
    host_req(1'b0, 10'd7, 8'h77);
    eng_req(8'd1, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      want_host = (c == 5) || (c == 10);
      @(negedge clk);
      checks++;
      if ({host_wr_ready, eng_req_ready} !== {want_host, !want_host})
        $display("FAIL boost_c%0d got hr=%b er=%b want %b/%b",
                 c, host_wr_ready, eng_req_ready, want_host, !want_host);
      else passed++;
      if (want_host) begin
        checks++;
        if ({bank_csb, bank_web, bank_addr0} !== {2'b10, 2'b10, 10'd7})
          $display("FAIL boost_wr_c%0d got csb=%b web=%b a0=%0d want 10/10/7",
                   c, bank_csb, bank_web, bank_addr0);
        else passed++;
      end else begin
        exp_q.push_back('{err: 1'b0, data: init0(10)});
      end
      tick();
    end
    // Two losses, then host idle for three cycles: count must be held.
    for (int c = 1; c <= 8; c++) begin
      if (c >= 3 && c <= 5) host_wr_valid = 1'b0;
      else                  host_req(1'b0, 10'd7, 8'h77);
      want_host = (c == 8);
      @(negedge clk);
      checks++;
      if (host_wr_ready !== want_host)
        $display("FAIL hold_c%0d got hr=%b want %b", c, host_wr_ready, want_host);
      else passed++;
      if (!want_host) exp_q.push_back('{err: 1'b0, data: init0(10)});
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_err();
    logic [7:0] px [3] = '{8'd196, 8'd5, 8'd255};
    logic [3:0] ot [3] = '{4'd0, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      eng_req(px[i], ot[i]);
      @(negedge clk);
      checks++;
      if ({eng_req_ready, bank_csb} !== 3'b1_11)
        $display("FAIL err%0d_ctrl got rdy=%b csb=%b want 1/11", i, eng_req_ready, bank_csb);
      else passed++;
      exp_q.push_back('{err: 1'b1, data: 8'h00});
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] px [4] = '{8'd3, 8'd97, 8'd98, 8'd195};
    logic [3:0] ot [4] = '{4'd7, 4'd9, 4'd0, 4'd9};
    logic       bk [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] ad [4] = '{10'd37, 10'd979, 10'd0, 10'd979};
    for (int i = 0; i < 4; i++) begin
      eng_req(px[i], ot[i]);
      @(negedge clk);
      checks++;
      if ((bk[i] ? bank_addr1 : bank_addr0) !== ad[i] || bank_csb[bk[i]] !== 1'b0)
        $display("FAIL b2b%0d_addr got a0=%0d a1=%0d csb=%b want bank%0d addr %0d",
                 i, bank_addr0, bank_addr1, bank_csb, bk[i], ad[i]);
      else passed++;
      exp_q.push_back('{err: 1'b0, data: bk[i] ? init1(int'(ad[i])) : init0(int'(ad[i]))});
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    // Two lost conflicts leave a non-zero wait count before reset.
    host_req(1'b0, 10'd7, 8'h77);
    eng_req(8'd1, 4'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      exp_q.push_back('{err: 1'b0, data: init0(10)});
      tick();
    end
    idle();
    eng_req(8'd3, 4'd7);
    @(negedge clk);
    exp_q.push_back('{err: 1'b0, data: 8'h5A});
    tick();
    rst = 1'b1;
    eng_req(8'd100, 4'd2);
    @(negedge clk);
    checks++;
    if (eng_req_ready !== 1'b0)
      $display("FAIL rstmid_ready got %b want 0", eng_req_ready);
    else passed++;
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({eng_rsp_valid, eng_rsp_err, eng_rsp_data} !== 10'd0)
      $display("FAIL rstmid_rsp got v=%b e=%b d=%h want 0", eng_rsp_valid, eng_rsp_err, eng_rsp_data);
    else passed++;
    tick();
    host_req(1'b0, 10'd7, 8'h77);
    eng_req(8'd1, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (host_wr_ready !== (c == 5))
        $display("FAIL rstmid_cnt_c%0d got hr=%b want %b", c, host_wr_ready, (c == 5));
      else passed++;
      if (c != 5) exp_q.push_back('{err: 1'b0, data: init0(10)});
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_read_bank0();
    test_read_bank1();
    test_parallel();
    test_boost();
    test_err();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain got %0d outstanding want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
